// File: rtl/baud_gen_pkg.sv
// Shared definitions for the baud-rate generator.
//   FracWidth      : width of the fractional divisor (sixteenths).
//   MaxDivWidth    : widest integer divisor the default-divisor helpers produce.
//   div_t          : integer/fraction divisor pair.
//   def_div()      : default divisor for a clock, baud rate and oversample ratio.
//   def_div_int()  : integer part of def_div().
//   def_div_frac() : fractional part of def_div().
package baud_gen_pkg;

  localparam int unsigned FracWidth   = 4;
  localparam int unsigned MaxDivWidth = 32;

  typedef struct packed {
    logic [MaxDivWidth-1:0] div_int;
    logic [FracWidth-1:0]   div_frac;
  } div_t;

  // D = floor(clk / (baud * os)), F = round(16 * remainder). A fraction that rounds
  // up to a whole clock is folded into D.
  function automatic div_t def_div(input int unsigned clk_hz, input int unsigned baud,
                                   input int unsigned os);
    longint unsigned clk, den, q, r, f;
    div_t            res;
    clk = 64'(clk_hz);
    den = 64'(baud) * 64'(os);
    q   = clk / den;
    r   = clk % den;
    f   = ((r << FracWidth) + (den >> 1)) / den;
    if (f == (64'(1) << FracWidth)) begin
      q = q + 64'd1;
      f = 64'd0;
    end
    res.div_int  = MaxDivWidth'(q);
    res.div_frac = FracWidth'(f);
    return res;
  endfunction

  function automatic int unsigned def_div_int(input int unsigned clk_hz,
                                              input int unsigned baud,
                                              input int unsigned os);
    div_t d;
    d = def_div(clk_hz, baud, os);
    return d.div_int;
  endfunction

  function automatic int unsigned def_div_frac(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned os);
    div_t d;
    d = def_div(clk_hz, baud, os);
    return 32'(d.div_frac);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator for baud_gen.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear of accumulator and pending extension
//   step_i : rx terminal count; add frac_i to the accumulator
//   frac_i : active fractional divisor (sixteenths)
//   ext_o  : carry from the last step; lengthens the current rx period by one clock
module baud_frac_acc
  import baud_gen_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 step_i,
  input  logic [FracWidth-1:0] frac_i,
  output logic                 ext_o
);

  logic [FracWidth-1:0] acc_q, acc_d;
  logic                 ext_q, ext_d;

  always_comb begin
    acc_d = acc_q;
    ext_d = ext_q;
    if (clr_i) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (step_i) begin
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
  end

  assign ext_o = ext_q;

endmodule

// File: rtl/baud_gen.sv
// Programmable fractional baud-rate generator.
//   clk_50m      : clock, all logic on its rising edge
//   rstn         : asynchronous active-low reset
//   en           : count enable; low freezes all counters
//   sync_clr     : phase realign strobe; clears counters, overrides en
//   cfg_load     : strobe capturing cfg_div_int / cfg_div_frac into the shadow divisor
//   cfg_div_int  : integer rx divisor in clocks (must be >= 2)
//   cfg_div_frac : fractional rx divisor in sixteenths
//   Rxclk_en     : one-cycle oversample tick
//   Txclk_en     : one-cycle bit tick, every OVERSAMPLE-th Rxclk_en
//   cfg_err      : sticky, set by a cfg_load with cfg_div_int < 2
// Build option: define BAUD_GEN_FRAC_EN to enable the fractional accumulator; without it
// cfg_div_frac is ignored and every rx period is exactly D clocks.
// OVERSAMPLE legal range is 2..32.
module baud_gen
  import baud_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_WIDTH    = 16
) (
  input  logic                 clk_50m,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 sync_clr,
  input  logic                 cfg_load,
  input  logic [DIV_WIDTH-1:0] cfg_div_int,
  input  logic [FracWidth-1:0] cfg_div_frac,
  output logic                 Rxclk_en,
  output logic                 Txclk_en,
  output logic                 cfg_err
);

  localparam div_t                 DefDiv  = def_div(CLK_FREQ_HZ, DEFAULT_BAUD, OVERSAMPLE);
  localparam logic [DIV_WIDTH-1:0] DefInt  = DIV_WIDTH'(DefDiv.div_int);
  localparam int unsigned          TxWidth = $clog2(OVERSAMPLE);
  localparam logic [TxWidth-1:0]   TxLast  = TxWidth'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [TxWidth-1:0]   tx_cnt_q, tx_cnt_d;
  logic [DIV_WIDTH-1:0] act_int_q, act_int_d;
  logic [DIV_WIDTH-1:0] shd_int_q, shd_int_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [DIV_WIDTH-1:0] rx_term;
  logic                 rx_ext;
  logic                 rx_wrap;
  logic                 cfg_legal;

  assign cfg_legal = cfg_div_int >= DIV_WIDTH'(2);

  // Terminal value is D-1, or D when the accumulator carried at the previous wrap.
  assign rx_term = act_int_q - DIV_WIDTH'(1) + DIV_WIDTH'(rx_ext);
  assign rx_wrap = en && !sync_clr && (rx_cnt_q == rx_term);

  always_comb begin
    rx_cnt_d  = rx_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    act_int_d = act_int_q;
    shd_int_d = shd_int_q;
    cfg_err_d = cfg_err_q;
    if (sync_clr) begin
      rx_cnt_d = '0;
      tx_cnt_d = '0;
    end else if (en) begin
      if (rx_wrap) begin
        rx_cnt_d  = '0;
        tx_cnt_d  = (tx_cnt_q == TxLast) ? '0 : tx_cnt_q + TxWidth'(1);
        // Divisor changes only on a period boundary; a load in this same cycle
        // lands in the shadow and waits for the next boundary.
        act_int_d = shd_int_q;
      end else begin
        rx_cnt_d = rx_cnt_q + DIV_WIDTH'(1);
      end
    end
    if (cfg_load) begin
      if (cfg_legal) begin
        shd_int_d = cfg_div_int;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      act_int_q <= DefInt;
      shd_int_q <= DefInt;
      cfg_err_q <= 1'b0;
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      act_int_q <= act_int_d;
      shd_int_q <= shd_int_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FracWidth-1:0] act_frac_q, act_frac_d;
  logic [FracWidth-1:0] shd_frac_q, shd_frac_d;

  always_comb begin
    act_frac_d = rx_wrap ? shd_frac_q : act_frac_q;
    shd_frac_d = (cfg_load && cfg_legal) ? cfg_div_frac : shd_frac_q;
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      act_frac_q <= DefDiv.div_frac;
      shd_frac_q <= DefDiv.div_frac;
    end else begin
      act_frac_q <= act_frac_d;
      shd_frac_q <= shd_frac_d;
    end
  end

  baud_frac_acc u_frac_acc (
    .clk_i  (clk_50m),
    .rst_ni (rstn),
    .clr_i  (sync_clr),
    .step_i (rx_wrap),
    .frac_i (act_frac_q),
    .ext_o  (rx_ext)
  );
`else
  logic unused_cfg_div_frac;
  assign unused_cfg_div_frac = ^cfg_div_frac;
  assign rx_ext              = 1'b0;
`endif

  assign Rxclk_en = rx_wrap;
  assign Txclk_en = rx_wrap && (tx_cnt_q == TxLast);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_baud_gen.sv
// Scoreboard bench for baud_gen: expected tick cycles are queued as stimulus is applied
// and popped as Rxclk_en pulses appear.
module tb_baud_gen;

  localparam int unsigned Os   = 16;
  localparam int unsigned DefD = 27;
  localparam int unsigned DefF = 2;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FracEn = 1'b1;
`else
  localparam bit FracEn = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        rstn;
  logic        en;
  logic        sync_clr;
  logic        cfg_load;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        Rxclk_en;
  logic        Txclk_en;
  logic        cfg_err;

  baud_gen #(
    .CLK_FREQ_HZ  (50000000),
    .DEFAULT_BAUD (115200),
    .OVERSAMPLE   (Os),
    .DIV_WIDTH    (16)
  ) dut (
    .clk_50m      (clk_50m),
    .rstn         (rstn),
    .en           (en),
    .sync_clr     (sync_clr),
    .cfg_load     (cfg_load),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .Rxclk_en     (Rxclk_en),
    .Txclk_en     (Txclk_en),
    .cfg_err      (cfg_err)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct {
    int unsigned cyc;
    bit          tx;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference period model state.
  int unsigned m_base, m_acc, m_tx, m_stall;
  int unsigned m_ext;

  always @(posedge clk_50m) cyc++;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic model_clear(input int unsigned base);
    m_base  = base;
    m_acc   = 0;
    m_ext   = 0;
    m_tx    = 0;
    m_stall = 0;
  endtask

  // Queue n ticks with divisor (d, f) active; m_stall adds gap cycles to the first one.
  task automatic push_ticks(input int n, input int unsigned d, input int unsigned f);
    exp_t        e;
    int unsigned len;
    for (int i = 0; i < n; i++) begin
      len     = d + m_ext + m_stall;
      m_stall = 0;
      e.cyc   = m_base + len - 1;
      e.tx    = (m_tx == Os - 1);
      sb_q.push_back(e);
      m_base  = m_base + len;
      m_tx    = (m_tx + 1) % Os;
      if (FracEn) begin
        m_acc = m_acc + f;
        m_ext = (m_acc >= 16) ? 1 : 0;
        m_acc = m_acc % 16;
      end
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb_q.size() != 0 && b > 0) begin
      step(1);
      b--;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  always @(negedge clk_50m) begin
    if (Txclk_en && !Rxclk_en) check_eq("tx_without_rx", Txclk_en, 0);
    if (Rxclk_en) begin
      if (sb_q.size() == 0) begin
        check_eq("rx_unexpected", Rxclk_en, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("rx_cycle", cyc, mon_e.cyc);
        check_eq("tx_flag", Txclk_en, mon_e.tx);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got cycle %0d expected bench to finish first", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned s;
    rstn         = 1'b0;
    en           = 1'b0;
    sync_clr     = 1'b0;
    cfg_load     = 1'b0;
    cfg_div_int  = '0;
    cfg_div_frac = '0;
    step(3);
    check_eq("rst_rx", Rxclk_en, 0);
    check_eq("rst_tx", Txclk_en, 0);
    check_eq("rst_err", cfg_err, 0);

    // Reset defaults: first tick 27 clocks after release, Txclk_en every 16th tick.
    en   = 1'b1;
    rstn = 1'b1;
    model_clear(cyc);
    push_ticks(34, DefD, DefF);
    drain(1500);

    // Runtime reload mid-period to D=10, F=0.
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    push_ticks(1, DefD, DefF);
    push_ticks(32, 10, 0);
    step(1);
    sync_clr = 1'b0;
    step(10);
    cfg_load     = 1'b1;
    cfg_div_int  = 16'd10;
    cfg_div_frac = 4'd0;
    step(1);
    cfg_load = 1'b0;
    drain(600);

    // Illegal write leaves the period alone; a later legal load keeps cfg_err set.
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    push_ticks(2, 10, 0);
    push_ticks(3, 20, 0);
    step(1);
    sync_clr = 1'b0;
    step(2);
    cfg_load     = 1'b1;
    cfg_div_int  = 16'd1;
    cfg_div_frac = 4'd5;
    step(1);
    cfg_load = 1'b0;
    check_eq("err_set", cfg_err, 1);
    step(10);
    cfg_load     = 1'b1;
    cfg_div_int  = 16'd20;
    cfg_div_frac = 4'd0;
    step(1);
    cfg_load = 1'b0;
    check_eq("err_sticky", cfg_err, 1);
    drain(200);

    // Enable gap of 5 at count 12, then a gap of 3 sitting on the terminal count.
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    m_stall = 5;
    push_ticks(1, 20, 0);
    m_stall = 3;
    push_ticks(1, 20, 0);
    push_ticks(2, 20, 0);
    step(1);
    sync_clr = 1'b0;
    step(12);
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(27);
    en = 1'b0;
    step(1);
    check_eq("gap_rx", Rxclk_en, 0);
    step(2);
    en = 1'b1;
    drain(200);

    // Realign at a random phase.
    step($urandom_range(1, 15));
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    push_ticks(16, 20, 0);
    step(1);
    sync_clr = 1'b0;
    drain(400);

    // Realign exactly on the terminal count: that tick is suppressed.
    step(19);
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    push_ticks(2, 20, 0);
    step(1);
    sync_clr = 1'b0;
    drain(100);

    // sync_clr while en is low still clears the counters.
    step(7);
    s        = cyc;
    en       = 1'b0;
    sync_clr = 1'b1;
    model_clear(s + 1);
    m_stall = 1;
    push_ticks(2, 20, 0);
    step(1);
    sync_clr = 1'b0;
    step(1);
    en = 1'b1;
    drain(100);

    // Smallest legal divisor.
    s        = cyc;
    sync_clr = 1'b1;
    model_clear(s + 1);
    push_ticks(1, 20, 0);
    push_ticks(20, 2, 0);
    step(1);
    sync_clr     = 1'b0;
    cfg_load     = 1'b1;
    cfg_div_int  = 16'd2;
    cfg_div_frac = 4'd0;
    step(1);
    cfg_load = 1'b0;
    drain(100);
    check_eq("err_still_set", cfg_err, 1);

    // Reset on a tick cycle: outputs drop at once, defaults come back.
    step(1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_rx", Rxclk_en, 0);
    check_eq("mid_rst_tx", Txclk_en, 0);
    check_eq("mid_rst_err", cfg_err, 0);
    step(3);
    model_clear(cyc);
    push_ticks(17, DefD, DefF);
    rstn = 1'b1;
    drain(800);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
